// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - two-write/two-read register file with sequenced clear engine
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic [ADDR_W-1:0] rd_addr0,
  output logic [DATA_W-1:0] rd_data0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_done_q, clr_done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              we0, we1;

  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Effective write strobes: writes only land while idle and never on a hardwired zero entry.
  assign we0 = (state_q == IDLE) && wr_en0 && !is_zero_addr(wr_addr0);
  assign we1 = (state_q == IDLE) && wr_en1 && !is_zero_addr(wr_addr1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_done_q <= clr_done_d;
    end
  end

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (we0) mem_q[wr_addr0] <= wr_data0;
      if (we1) mem_q[wr_addr1] <= wr_data1;
    end
  end

  always_comb begin
    rd_data0 = mem_q[rd_addr0];
`ifdef REGFILE_BYPASS_EN
    if (we0 && (wr_addr0 == rd_addr0)) rd_data0 = wr_data0;
    if (we1 && (wr_addr1 == rd_addr0)) rd_data0 = wr_data1;
`endif
    if (is_zero_addr(rd_addr0)) rd_data0 = '0;
  end

  always_comb begin
    rd_data1 = mem_q[rd_addr1];
`ifdef REGFILE_BYPASS_EN
    if (we0 && (wr_addr0 == rd_addr1)) rd_data1 = wr_data0;
    if (we1 && (wr_addr1 == rd_addr1)) rd_data1 = wr_data1;
`endif
    if (is_zero_addr(rd_addr1)) rd_data1 = '0;
  end

  assign busy     = (state_q == CLEAR);
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized self-checking bench for regfile_mp (ZERO_REG=1 and ZERO_REG=0)
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en0, wr_en1, clr_req;
  logic [4:0]  wr_addr0, wr_addr1, rd_addr0, rd_addr1;
  logic [31:0] wr_data0, wr_data1;
  logic [31:0] rd_data0, rd_data1, nz_rd_data0, nz_rd_data1;
  logic        busy, clr_done, nz_busy, nz_clr_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: index 0 mirrors the ZERO_REG=1 instance, index 1 the ZERO_REG=0 instance.
  logic [31:0] m_mem [2][32];
  int          m_clr;
  logic        m_done;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut (
    .clk(clk), .reset(reset),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .rd_addr0(rd_addr0), .rd_data0(rd_data0),
    .rd_addr1(rd_addr1), .rd_data1(rd_data1),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut_nz (
    .clk(clk), .reset(reset),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .rd_addr0(rd_addr0), .rd_data0(nz_rd_data0),
    .rd_addr1(rd_addr1), .rd_data1(nz_rd_data1),
    .clr_req(clr_req), .busy(nz_busy), .clr_done(nz_clr_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) m_mem[k][i] = '0;
    m_clr  = -1;
    m_done = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input int k, input logic [4:0] a);
    if (k == 0 && a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (m_clr < 0) begin
      if (wr_en1 && wr_addr1 == a) return wr_data1;
      if (wr_en0 && wr_addr0 == a) return wr_data0;
    end
`endif
    return m_mem[k][a];
  endfunction

  task automatic model_edge();
    m_done = 1'b0;
    if (m_clr < 0) begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en0 && !(k == 0 && wr_addr0 == 5'd0)) m_mem[k][wr_addr0] = wr_data0;
        if (wr_en1 && !(k == 0 && wr_addr1 == 5'd0)) m_mem[k][wr_addr1] = wr_data1;
      end
      if (clr_req) m_clr = 0;
    end else begin
      for (int k = 0; k < 2; k++) m_mem[k][m_clr] = '0;
      m_clr++;
      if (m_clr == 32) begin
        m_clr  = -1;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check("busy",        32'(busy),        32'(m_clr >= 0));
    check("clr_done",    32'(clr_done),    32'(m_done));
    check("nz_busy",     32'(nz_busy),     32'(m_clr >= 0));
    check("nz_clr_done", 32'(nz_clr_done), 32'(m_done));
    check("rd0",    rd_data0,    exp_rd(0, rd_addr0));
    check("rd1",    rd_data1,    exp_rd(0, rd_addr1));
    check("nz_rd0", nz_rd_data0, exp_rd(1, rd_addr0));
    check("nz_rd1", nz_rd_data1, exp_rd(1, rd_addr1));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    sample();
    tick();
  endtask

  task automatic idle_inputs();
    wr_en0 = 1'b0; wr_en1 = 1'b0; clr_req = 1'b0;
  endtask

  task automatic sweep();
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      rd_addr0 = 5'(i);
      rd_addr1 = 5'(31 - i);
      step();
    end
  endtask

  task automatic rand_writes();
    wr_en0   = 1'($urandom);
    wr_en1   = 1'($urandom);
    wr_addr0 = 5'($urandom);
    wr_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr0 : 5'($urandom);
    wr_data0 = $urandom;
    wr_data1 = $urandom;
    rd_addr0 = ($urandom_range(0, 2) == 0) ? wr_addr1 : 5'($urandom);
    rd_addr1 = ($urandom_range(0, 2) == 0) ? wr_addr0 : 5'($urandom);
  endtask

  initial begin
    int busy_cnt, done_cnt;
    reset = 1'b1;
    idle_inputs();
    wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
    rd_addr0 = 5'd5; rd_addr1 = 5'd6;
    model_reset();
    #1;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(clr_done), 32'h0);
    check("reset_rd0", rd_data0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic write then read-back on the next cycle.
    wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'hDEADBEEF;
    step();
    idle_inputs();
    sample();
    check("wr5_rd0", rd_data0, 32'hDEADBEEF);
    check("wr5_rd1", rd_data1, 32'h0);
    tick();

    // Same-address collision: port 1 wins.
    wr_en0 = 1'b1; wr_addr0 = 5'd9; wr_data0 = 32'h1111_1111;
    wr_en1 = 1'b1; wr_addr1 = 5'd9; wr_data1 = 32'h2222_2222;
    rd_addr0 = 5'd9;
    step();
    idle_inputs();
    sample();
    check("collide_rd0", rd_data0, 32'h2222_2222);
    tick();

    // Entry 0: hardwired zero vs ordinary register.
    wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    rd_addr0 = 5'd0;
    sample();
    check("zero_reg_rd0", rd_data0, 32'h0);
    check("nz_reg_rd0", nz_rd_data0, 32'hFFFF_FFFF);
    tick();

    // Forwarding: same-cycle value depends on build configuration.
    wr_en1 = 1'b1; wr_addr1 = 5'd3; wr_data1 = 32'hCAFE0001; rd_addr1 = 5'd3;
    sample();
`ifdef REGFILE_BYPASS_EN
    check("bypass_same", rd_data1, 32'hCAFE0001);
`else
    check("bypass_same", rd_data1, 32'h0);
`endif
    tick();
    idle_inputs();
    sample();
    check("bypass_next", rd_data1, 32'hCAFE0001);
    tick();

    // Fill with index, then a single-cycle clear request with writes hammering during busy.
    for (int i = 0; i < 16; i++) begin
      wr_en0 = 1'b1; wr_addr0 = 5'(2 * i);     wr_data0 = 32'(2 * i);
      wr_en1 = 1'b1; wr_addr1 = 5'(2 * i + 1); wr_data1 = 32'(2 * i + 1);
      rd_addr0 = 5'(2 * i); rd_addr1 = 5'(2 * i + 1);
      step();
    end
    sweep();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      rand_writes();
      sample();
      if (busy) busy_cnt++;
      if (clr_done) done_cnt++;
      tick();
      if (c == 31) idle_inputs();
    end
    idle_inputs();
    check("clear_busy_cycles", 32'(busy_cnt), 32'd32);
    check("clear_done_pulses", 32'(done_cnt), 32'd1);
    sweep();

    // Back-to-back clears with clr_req held.
    for (int i = 0; i < 32; i++) begin
      wr_en0 = 1'b1; wr_addr0 = 5'(i); wr_data0 = $urandom;
      step();
    end
    clr_req = 1'b1;
    for (int c = 0; c < 70; c++) begin
      wr_en0 = 1'b1; wr_addr0 = 5'($urandom); wr_data0 = $urandom;
      rd_addr0 = 5'($urandom); rd_addr1 = 5'($urandom);
      step();
    end
    idle_inputs();
    for (int c = 0; c < 34; c++) step();

    // Reset in the middle of a clear.
    for (int i = 0; i < 32; i++) begin
      wr_en1 = 1'b1; wr_addr1 = 5'(i); wr_data1 = $urandom | 32'h1;
      step();
    end
    idle_inputs();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 0; c < 10; c++) step();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check("midclr_busy", 32'(busy), 32'h0);
    check("midclr_done", 32'(clr_done), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    sweep();

    // Random traffic with occasional clear requests.
    for (int c = 0; c < 400; c++) begin
      rand_writes();
      clr_req = ($urandom_range(0, 39) == 0);
      step();
    end
    idle_inputs();
    for (int c = 0; c < 34; c++) step();
    sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
